// File: rtl/spi_cmd_tx.sv
// SPI mode-0 command transmitter: shifts an {cmd, data} packet out MSB first with
// chip-select framing, fixed setup/hold/gap windows and registered outputs.
module spi_cmd_tx #(
    parameter int unsigned PACKET_WIDTH = 24,
    parameter int unsigned DATA_WIDTH   = PACKET_WIDTH - 8,
    parameter int unsigned HALF_PERIOD  = 4
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [7:0]            cmd_word,
    input  logic [DATA_WIDTH-1:0] data_word,
    input  logic                  valid,
    output logic                  ready,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  csb
);

    localparam int unsigned BitW = (PACKET_WIDTH > 1) ? $clog2(PACKET_WIDTH) : 1;
    localparam int unsigned HpW  = $clog2(HALF_PERIOD);
    localparam logic [BitW-1:0] LastBit = BitW'(PACKET_WIDTH - 1);
    localparam logic [HpW-1:0]  LastHp  = HpW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    state_e                  state_q, state_d;
    logic [BitW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [HpW-1:0]          hp_cnt_q, hp_cnt_d;
    logic                    phase_q, phase_d;
    logic [PACKET_WIDTH-1:0] shift_q, shift_d;

    logic ready_q, ready_d;
    logic done_q, done_d;
    logic sclk_q, sclk_d;
    logic mosi_q, mosi_d;
    logic csb_q, csb_d;

    logic hp_tick;
    logic accept;
    logic in_frame;

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            hp_cnt_q  <= '0;
            phase_q   <= 1'b0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            hp_cnt_q  <= hp_cnt_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic. phase_q is the sclk level of the current SHIFT half-period.
    always_comb begin
        hp_tick   = (hp_cnt_q == LastHp);
        accept    = valid && ready_q;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        hp_cnt_d  = '0;
        if (state_q != StIdle) begin
            hp_cnt_d = hp_tick ? '0 : hp_cnt_q + HpW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StSetup;
                    shift_d   = {cmd_word, data_word};
                    bit_cnt_d = '0;
                    phase_d   = 1'b0;
                end
            end
            StSetup: begin
                if (hp_tick) begin
                    state_d = StShift;
                    phase_d = 1'b0;
                end
            end
            StShift: begin
                if (hp_tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_cnt_q == LastBit) begin
                        // Final falling edge: keep the last bit on mosi through HOLD.
                        state_d = StHold;
                        phase_d = 1'b0;
                    end else begin
                        phase_d   = 1'b0;
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        shift_d   = {shift_q[PACKET_WIDTH-2:0], 1'b0};
                    end
                end
            end
            StHold: begin
                if (hp_tick) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (hp_tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from next state so every output leaves a flop.
    always_comb begin
        in_frame = (state_d == StSetup) || (state_d == StShift) || (state_d == StHold);
        ready_d  = (state_d == StIdle);
        done_d   = (state_q == StHold) && (state_d == StGap);
        csb_d    = !in_frame;
        sclk_d   = (state_d == StShift) && phase_d;
        mosi_d   = in_frame && shift_d[PACKET_WIDTH-1];
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csb_q   <= 1'b1;
        end else begin
            ready_q <= ready_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csb_q   <= csb_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign csb   = csb_q;

endmodule
